// File: rtl/core_reset_pkg.sv
// Shared types for the core reset controller: FSM state encoding and
// the counter-width helper used by the top and the stretch counter.
package core_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_ROM = 2'd0,
    HOLD     = 2'd1,
    RUN      = 2'd2,
    LOADING  = 2'd3
  } state_e;

  localparam int unsigned IDX_W = 8;

  // A zero-cycle hold still needs a 1-bit counter to express "zero".
  function automatic int unsigned cnt_width(input int unsigned hold);
    return (hold == 0) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/reset_stretch.sv
// Reload/decrement counter that stretches core reset; saturates at zero
// and reports when it has expired.
module reset_stretch #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned HOLD_CYCLES = 65535
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: reload wins over decrement, no wrap below zero.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= CNT_W'(HOLD_CYCLES);
    end else if (load) begin
      cnt_r <= CNT_W'(HOLD_CYCLES);
    end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/core_reset_ctrl.sv
// Core reset sequencer: tracks ROM downloads per slot and holds the core
// in reset until required slots are loaded and the reset stretch expires.
module core_reset_ctrl
  import core_reset_pkg::*;
#(
  parameter int unsigned              NUM_SLOTS   = 4,
  parameter logic [NUM_SLOTS-1:0]     REQ_MASK    = 4'b0001,
  parameter logic [NUM_SLOTS-1:0]     RST_ON_LOAD = 4'b0001,
  parameter int unsigned              HOLD_CYCLES = 65535,
  parameter int unsigned              SRC_W       = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [SRC_W-1:0]     rst_req,
  input  logic                 ioctl_download,
  input  logic [IDX_W-1:0]     ioctl_index,
  output logic                 core_reset,
  output logic [NUM_SLOTS-1:0] rom_loaded,
  output logic                 all_loaded,
  output logic                 load_done,
  output logic [IDX_W-1:0]     load_index,
  output logic [1:0]           state
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES);

  state_e               state_r, state_next_s;
  logic                 dl_d_r, armed_r, busy_r;
  logic                 load_done_r, all_loaded_r, core_reset_r;
  logic [IDX_W-1:0]     load_index_r;
  logic [NUM_SLOTS-1:0] rom_loaded_r, rom_loaded_next_s;
  logic                 all_loaded_next_s;
  logic                 rise_s, fall_s, trig_s, req_any_s;
  logic                 cnt_load_s, cnt_en_s, cnt_zero_s;

  function automatic logic slot_hit(input logic [IDX_W-1:0] idx,
                                    input logic [NUM_SLOTS-1:0] mask);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == IDX_W'(i)) hit = mask[i];
    end
    return hit;
  endfunction

  // armed_r blocks a download already in flight when reset released.
  assign rise_s    = ioctl_download & ~dl_d_r & armed_r;
  assign fall_s    = ~ioctl_download & dl_d_r & busy_r;
  assign trig_s    = rise_s & slot_hit(ioctl_index, RST_ON_LOAD);
  assign req_any_s = |rst_req;

  // Completion flags for this cycle, including a download ending now.
  always_comb begin
    rom_loaded_next_s = rom_loaded_r;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (fall_s && (load_index_r == IDX_W'(i))) begin
        rom_loaded_next_s[i] = 1'b1;
      end else begin
        rom_loaded_next_s[i] = rom_loaded_r[i];
      end
    end
    all_loaded_next_s = ((rom_loaded_next_s & REQ_MASK) == REQ_MASK);
  end

  // Next-state and counter control.
  always_comb begin
    state_next_s = state_r;
    cnt_load_s   = 1'b0;
    cnt_en_s     = 1'b0;
    case (state_r)
      WAIT_ROM: begin
        if (all_loaded_r) begin
          state_next_s = HOLD;
          cnt_load_s   = 1'b1;
        end else begin
          state_next_s = WAIT_ROM;
        end
      end
      HOLD: begin
        if (trig_s) begin
          state_next_s = LOADING;
        end else if (req_any_s) begin
          cnt_load_s = 1'b1;
        end else if (cnt_zero_s) begin
          state_next_s = RUN;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      RUN: begin
        if (trig_s) begin
          state_next_s = LOADING;
        end else if (req_any_s) begin
          state_next_s = HOLD;
          cnt_load_s   = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      LOADING: begin
        if (fall_s) begin
          if (all_loaded_next_s) begin
            state_next_s = HOLD;
            cnt_load_s   = 1'b1;
          end else begin
            state_next_s = WAIT_ROM;
          end
        end else begin
          state_next_s = LOADING;
        end
      end
      default: begin
        state_next_s = WAIT_ROM;
      end
    endcase
  end

  // Download tracking, flags and FSM state registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_d_r       <= 1'b0;
      armed_r      <= 1'b0;
      busy_r       <= 1'b0;
      load_index_r <= {IDX_W{1'b0}};
      load_done_r  <= 1'b0;
      rom_loaded_r <= {NUM_SLOTS{1'b0}};
      all_loaded_r <= 1'b0;
      state_r      <= WAIT_ROM;
      core_reset_r <= 1'b1;
    end else begin
      dl_d_r       <= ioctl_download;
      armed_r      <= armed_r | ~ioctl_download;
      if (rise_s) begin
        busy_r       <= 1'b1;
        load_index_r <= ioctl_index;
      end else if (!ioctl_download) begin
        busy_r       <= 1'b0;
        load_index_r <= load_index_r;
      end else begin
        busy_r       <= busy_r;
        load_index_r <= load_index_r;
      end
      load_done_r  <= fall_s;
      rom_loaded_r <= rom_loaded_next_s;
      all_loaded_r <= all_loaded_next_s;
      state_r      <= state_next_s;
      core_reset_r <= (state_next_s != RUN);
    end
  end

  reset_stretch #(
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_stretch (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (cnt_load_s),
    .en      (cnt_en_s),
    .zero    (cnt_zero_s)
  );

  assign core_reset = core_reset_r;
  assign rom_loaded = rom_loaded_r;
  assign all_loaded = all_loaded_r;
  assign load_done  = load_done_r;
  assign load_index = load_index_r;
  assign state      = state_r;

endmodule

// File: tb/tb_core_reset_ctrl.sv
// Directed bench for core_reset_ctrl: download sequencing, reset stretch,
// reset requests, non-resetting slots, mid-download reset and zero hold.
module tb_core_reset_ctrl;
  import core_reset_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [1:0] rst_req;
  logic       ioctl_download;
  logic [7:0] ioctl_index;

  logic       core_reset, all_loaded, load_done;
  logic [3:0] rom_loaded;
  logic [7:0] load_index;
  logic [1:0] state;

  logic       z_core_reset, z_all_loaded, z_load_done;
  logic [3:0] z_rom_loaded;
  logic [7:0] z_load_index;
  logic [1:0] z_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  core_reset_ctrl #(
    .NUM_SLOTS(4), .REQ_MASK(4'b0011), .RST_ON_LOAD(4'b0001),
    .HOLD_CYCLES(8), .SRC_W(2)
  ) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .rst_req(rst_req),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .core_reset(core_reset), .rom_loaded(rom_loaded), .all_loaded(all_loaded),
    .load_done(load_done), .load_index(load_index), .state(state)
  );

  core_reset_ctrl #(
    .NUM_SLOTS(4), .REQ_MASK(4'b0011), .RST_ON_LOAD(4'b0001),
    .HOLD_CYCLES(0), .SRC_W(2)
  ) u_dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .rst_req(rst_req),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .core_reset(z_core_reset), .rom_loaded(z_rom_loaded), .all_loaded(z_all_loaded),
    .load_done(z_load_done), .load_index(z_load_index), .state(z_state)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic download(input logic [7:0] idx, input int len);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick(len);
    ioctl_download = 1'b0;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n        = 1'b0;
    rst_req        = 2'b00;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    #12;
    check_val("rst_core_reset", core_reset, 1'b1);
    check_val("rst_rom_loaded", rom_loaded, 4'b0000);
    check_val("rst_all_loaded", all_loaded, 1'b0);
    check_val("rst_load_done",  load_done,  1'b0);
    check_val("rst_load_index", load_index, 8'd0);
    check_val("rst_state",      state,      WAIT_ROM);
    #10;
    reset_n = 1'b1;
    tick(3);

    // Only slot 0 loaded: slot 1 still required.
    download(8'd0, 3);
    check_val("dl0_load_done",  load_done,  1'b1);
    check_val("dl0_load_index", load_index, 8'd0);
    check_val("dl0_rom_loaded", rom_loaded, 4'b0001);
    tick(1);
    check_val("dl0_pulse_end",  load_done,  1'b0);
    check_val("dl0_state",      state,      WAIT_ROM);
    check_val("dl0_core_reset", core_reset, 1'b1);
    check_val("dl0_all_loaded", all_loaded, 1'b0);

    // Slot 1 completes the required set: HOLD, then RUN after 9 cycles.
    download(8'd1, 3);
    check_val("dl1_load_done",  load_done,  1'b1);
    check_val("dl1_load_index", load_index, 8'd1);
    check_val("dl1_rom_loaded", rom_loaded, 4'b0011);
    check_val("dl1_all_loaded", all_loaded, 1'b1);
    tick(1);
    check_val("hold_enter_state", state,      HOLD);
    check_val("hold_enter_cr",    core_reset, 1'b1);
    check_val("z_hold_state",     z_state,    HOLD);
    tick(1);
    check_val("z_run_state",      z_state,      RUN);
    check_val("z_run_cr",         z_core_reset, 1'b0);
    check_val("hold_mid_state",   state,        HOLD);
    tick(7);
    check_val("hold_last_cr",     core_reset, 1'b1);
    check_val("hold_last_state",  state,      HOLD);
    tick(1);
    check_val("run_cr",           core_reset, 1'b0);
    check_val("run_state",        state,      RUN);

    // Reset request for 3 cycles from RUN.
    rst_req = 2'b10;
    tick(1);
    check_val("req_state",    state,      HOLD);
    check_val("req_cr",       core_reset, 1'b1);
    tick(2);
    rst_req = 2'b00;
    tick(8);
    check_val("req_last_cr",  core_reset, 1'b1);
    tick(1);
    check_val("req_run_cr",   core_reset, 1'b0);
    check_val("req_run_state", state,     RUN);

    // Resetting download with request held: LOADING has priority.
    rst_req        = 2'b01;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick(1);
    check_val("ld_state",      state,      LOADING);
    check_val("ld_cr",         core_reset, 1'b1);
    tick(3);
    check_val("ld_state_hold", state,      LOADING);
    ioctl_download = 1'b0;
    tick(1);
    check_val("ld_fall_state", state,      HOLD);
    check_val("ld_fall_done",  load_done,  1'b1);
    tick(12);
    check_val("ld_req_state",  state,      HOLD);
    check_val("ld_req_cr",     core_reset, 1'b1);
    rst_req = 2'b00;
    tick(8);
    check_val("ld_rel_last_cr", core_reset, 1'b1);
    tick(1);
    check_val("ld_rel_cr",     core_reset, 1'b0);
    check_val("ld_rel_state",  state,      RUN);

    // Out-of-range and non-resetting slots leave the FSM alone.
    download(8'd5, 2);
    check_val("dl5_load_done",  load_done,  1'b1);
    check_val("dl5_load_index", load_index, 8'd5);
    check_val("dl5_rom_loaded", rom_loaded, 4'b0011);
    check_val("dl5_state",      state,      RUN);
    check_val("dl5_cr",         core_reset, 1'b0);
    download(8'd2, 2);
    check_val("dl2_load_done",  load_done,  1'b1);
    check_val("dl2_load_index", load_index, 8'd2);
    check_val("dl2_rom_loaded", rom_loaded, 4'b0111);
    check_val("dl2_state",      state,      RUN);
    check_val("dl2_cr",         core_reset, 1'b0);

    // Reset asserted in the middle of a slot 1 download.
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    tick(2);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("mid_cr",         core_reset, 1'b1);
    check_val("mid_rom_loaded", rom_loaded, 4'b0000);
    check_val("mid_all_loaded", all_loaded, 1'b0);
    check_val("mid_load_done",  load_done,  1'b0);
    check_val("mid_load_index", load_index, 8'd0);
    check_val("mid_state",      state,      WAIT_ROM);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    ioctl_download = 1'b0;
    tick(1);
    check_val("trail_load_done",  load_done,  1'b0);
    check_val("trail_rom_loaded", rom_loaded, 4'b0000);
    tick(1);
    check_val("trail_rom_late",   rom_loaded, 4'b0000);
    check_val("trail_state",      state,      WAIT_ROM);
    check_val("trail_cr",         core_reset, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_reset_ctrl.md
CORE_RESET_CTRL -- requirements
Module: core_reset_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of tracked download indices (0..NUM_SLOTS-1).
REQ-002 SHALL have parameter REQ_MASK [NUM_SLOTS-1:0], default 4'b0001: slots that must be loaded before the core may run.
REQ-003 SHALL have parameter RST_ON_LOAD [NUM_SLOTS-1:0], default 4'b0001: slots whose download holds the core in reset.
REQ-004 SHALL have parameter HOLD_CYCLES, default 65535: reset stretch length; CNT_W = $clog2(HOLD_CYCLES+1).
REQ-005 SHALL have parameter SRC_W, default 2: number of reset request sources.
REQ-006 SHALL have port clk_sys  input  1  system clock; all logic is single-clock on its rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rst_req  input  SRC_W  level reset requests (menu reset, button), synchronous to clk_sys.
REQ-009 SHALL have port ioctl_download  input  1  download-active level.
REQ-010 SHALL have port ioctl_index  input  8  download slot index.
REQ-011 SHALL have port core_reset  output  1  active-high core reset, registered.
REQ-012 SHALL have port rom_loaded  output  NUM_SLOTS  per-slot "download completed" flags, sticky.
REQ-013 SHALL have port all_loaded  output  1  (rom_loaded & REQ_MASK) == REQ_MASK, registered.
REQ-014 SHALL have port load_done  output  1  one-cycle pulse on download completion.
REQ-015 SHALL have port load_index  output  8  index of the last completed download.
REQ-016 SHALL have port state  output  2  current FSM state, for debug.

Function
REQ-017 SHALL register ioctl_download once (dl_d); rise = download & ~dl_d; fall = ~download & dl_d.
REQ-018 SHALL latch ioctl_index into load_index on rise; completion uses the latched index, not the live input.
REQ-019 On fall, SHALL pulse load_done for exactly one cycle and set rom_loaded[load_index] if load_index < NUM_SLOTS; indices >= NUM_SLOTS pulse load_done but set no flag.
REQ-020 SHALL implement states WAIT_ROM=0, HOLD=1, RUN=2, LOADING=3.
REQ-021 WAIT_ROM: SHALL move to HOLD once all_loaded is 1, loading the counter with HOLD_CYCLES.
REQ-022 HOLD: SHALL reload the counter with HOLD_CYCLES while any rst_req bit is 1; otherwise SHALL decrement it; at counter==0 with no request, SHALL move to RUN.
REQ-023 RUN: any rst_req bit 1 SHALL cause a move to HOLD and a counter reload.
REQ-024 From HOLD or RUN, a rise whose live ioctl_index < NUM_SLOTS with RST_ON_LOAD set SHALL cause a move to LOADING; this takes priority over rst_req.
REQ-025 LOADING: SHALL ignore rst_req; on fall SHALL move to HOLD with a reload if all_loaded (including the flag set this cycle), else to WAIT_ROM.
REQ-026 SHALL drive core_reset as a flop of (next_state != RUN): it is low exactly HOLD_CYCLES+1 cycles after entering HOLD, absent requests.
REQ-027 Downloads of slots without RST_ON_LOAD SHALL update flags only and SHALL NOT disturb the FSM or counter.
REQ-028 With HOLD_CYCLES=0, the FSM SHALL spend exactly one cycle in HOLD.

Reset
REQ-029 reset_n low SHALL asynchronously set: state=WAIT_ROM, core_reset=1, rom_loaded=0, all_loaded=0, load_done=0, load_index=0, dl_d=0, counter=HOLD_CYCLES.
REQ-030 Assertion of reset_n mid-download SHALL discard that download; a fall not preceded by a rise after reset SHALL NOT set any flag.

Structure
REQ-031 The state enum and its 2-bit encoding SHALL live in package core_reset_pkg.
REQ-032 The reload/decrement counter SHALL be a sub-module reset_stretch (params CNT_W, HOLD_CYCLES; ports load, en, zero).

Verification (NUM_SLOTS=4, REQ_MASK=4'b0011, RST_ON_LOAD=4'b0001, HOLD_CYCLES=8)
REQ-033 Download idx0 only -> rom_loaded=0001, state WAIT_ROM, core_reset stays 1.
REQ-034 Then download idx1 -> load_done pulse with load_index=1; HOLD entered; core_reset falls 9 cycles later; state=RUN.
REQ-035 In RUN, pulse rst_req=2'b10 for 3 cycles -> HOLD; core_reset low again 9 cycles after rst_req drops.
REQ-036 In RUN, download idx0 with rst_req=01 held throughout -> LOADING for the whole download; HOLD on fall; rst_req then keeps reloading the counter.
REQ-037 In RUN, download idx5 and idx2 -> no FSM change, core_reset stays 0; rom_loaded=0111; load_done pulses twice.
REQ-038 Deassert reset_n mid-download of idx1 -> all outputs at reset values immediately; the trailing fall sets no flag.
